// File: rtl/bfly_stage_param.sv
// Sign-magnitude butterfly / (1+COEF) scale / bypass over LANES words, pairs STRIDE apart.
// Latency 2 cycles (input register, compute register); full-rate valid/ready, IN_READY drops only when both stages hold and OUT_READY is low.
module bfly_stage_param #(
    parameter int               W          = 12,
    parameter int               LANES      = 8,
    parameter int               STRIDE     = 1,
    parameter int unsigned      COEF       = 13573,
    parameter logic [LANES-1:0] SCALE_MASK = LANES'(8'b0011_0011)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [1:0]         IN_MODE,
    input  logic [LANES*W-1:0] IN_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [LANES*W-1:0] OUT_DATA,
    output logic               OUT_SAT,
    output logic               SAT_STICKY,
    input  logic               CLR_SAT
);
    localparam int MW = W - 1;
    localparam int PW = MW + 15;
    localparam logic [MW-1:0] MAXM = '1;

    typedef struct packed {
        logic         sat;
        logic [W-1:0] word;
    } res_t;

    // mag is one bit wider than a lane magnitude so sums can overflow visibly before clamping
    function automatic res_t sm_pack(input logic s, input logic [W-1:0] mag);
        res_t r;
        r.sat  = (mag > {1'b0, MAXM});
        r.word = {s & (mag != '0), (r.sat ? MAXM : mag[MW-1:0])};
        return r;
    endfunction

    function automatic res_t sm_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic neg_b);
        logic         sa, sb, s;
        logic [W-1:0] ma, mb, m;
        sa = a[W-1];
        sb = b[W-1] ^ neg_b;
        ma = {1'b0, a[MW-1:0]};
        mb = {1'b0, b[MW-1:0]};
        if (sa == sb) begin
            m = ma + mb;
            s = sa;
        end else if (ma >= mb) begin
            m = ma - mb;
            s = sa;
        end else begin
            m = mb - ma;
            s = sb;
        end
        return sm_pack(s, m);
    endfunction

    function automatic res_t sm_scale(input logic [W-1:0] a);
        logic [PW-1:0] prod;
        prod = {15'd0, a[MW-1:0]} * PW'(COEF);
        return sm_pack(a[W-1], {1'b0, a[MW-1:0]} + W'(prod >> 15));
    endfunction

    function automatic res_t sm_pass(input logic [W-1:0] a);
        return sm_pack(a[W-1], {1'b0, a[MW-1:0]});
    endfunction

    logic               rdy_en_q;
    logic               s1_vld_q;
    logic [1:0]         s1_mode_q;
    logic [LANES*W-1:0] s1_dat_q;
    logic               s2_vld_q;
    logic [LANES*W-1:0] s2_dat_q, s2_dat_d;
    logic               s2_sat_q, s2_sat_d;
    logic               sticky_q, sticky_d;
    logic               adv1, adv2, in_fire;
    res_t               lane_r [LANES];

    assign adv2     = ~s2_vld_q | OUT_READY;
    assign adv1     = ~s1_vld_q | adv2;
    assign IN_READY = rdy_en_q & adv1;
    assign in_fire  = IN_VALID & IN_READY;

    for (genvar g = 0; g < LANES; g++) begin : g_pair
        if (((g / STRIDE) % 2) == 0) begin : g_lo
            localparam int H = g + STRIDE;
            logic [W-1:0] lo, hi;
            res_t         bf_sum, bf_dif, r_lo, r_hi;

            assign lo     = s1_dat_q[g*W +: W];
            assign hi     = s1_dat_q[H*W +: W];
            assign bf_sum = sm_add(lo, hi, 1'b0);
            assign bf_dif = sm_add(lo, hi, 1'b1);

            // modes 2 and 3 pass the raw words, including any -0
            always_comb begin
                r_lo = {1'b0, lo};
                r_hi = {1'b0, hi};
                if (s1_mode_q == 2'd0 ||
                    (s1_mode_q == 2'd1 && !SCALE_MASK[g] && !SCALE_MASK[H])) begin
                    r_lo = bf_sum;
                    r_hi = bf_dif;
                end else if (s1_mode_q == 2'd1) begin
                    r_lo = SCALE_MASK[g] ? sm_scale(lo) : sm_pass(lo);
                    r_hi = SCALE_MASK[H] ? sm_scale(hi) : sm_pass(hi);
                end
            end

            assign lane_r[g] = r_lo;
            assign lane_r[H] = r_hi;
        end
    end

    always_comb begin
        s2_dat_d = '0;
        s2_sat_d = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            s2_dat_d[k*W +: W] = lane_r[k].word;
            s2_sat_d           = s2_sat_d | lane_r[k].sat;
        end
    end

    assign sticky_d = (s2_vld_q & OUT_READY & s2_sat_q) | (sticky_q & ~CLR_SAT);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdy_en_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_mode_q <= 2'd0;
            s1_dat_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_dat_q  <= '0;
            s2_sat_q  <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            sticky_q <= sticky_d;
            if (adv1) begin
                s1_vld_q <= in_fire;
                if (in_fire) begin
                    s1_mode_q <= IN_MODE;
                    s1_dat_q  <= IN_DATA;
                end
            end
            if (adv2) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_dat_q <= s2_dat_d;
                    s2_sat_q <= s2_sat_d;
                end
            end
        end
    end

    assign OUT_VALID  = s2_vld_q;
    assign OUT_DATA   = s2_dat_q;
    assign OUT_SAT    = s2_sat_q;
    assign SAT_STICKY = sticky_q;

endmodule

// File: tb/tb_bfly_stage_param.sv
// Directed bench for bfly_stage_param: default stage (STRIDE 1) plus a STRIDE 4 stage with a mismatched scale mask.
// Expected results are pushed on accept and popped by per-DUT monitors on each output handshake.
module tb_bfly_stage_param;
    localparam int W  = 12;
    localparam int L  = 8;
    localparam int DW = L * W;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, in_vld, in_rdy, out_vld, out_rdy, out_sat, sticky, clr_sat;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_dat, out_dat;
    logic          b_in_vld, b_in_rdy, b_out_vld, b_out_sat, b_sticky;
    logic [1:0]    b_in_mode;
    logic [DW-1:0] b_in_dat, b_out_dat;

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    bfly_stage_param dut (
        .CLK(clk), .RESET_N(rst_n),
        .IN_VALID(in_vld), .IN_READY(in_rdy), .IN_MODE(in_mode), .IN_DATA(in_dat),
        .OUT_VALID(out_vld), .OUT_READY(out_rdy), .OUT_DATA(out_dat), .OUT_SAT(out_sat),
        .SAT_STICKY(sticky), .CLR_SAT(clr_sat)
    );

    bfly_stage_param #(.STRIDE(4), .SCALE_MASK(8'b0000_0011)) dut_b (
        .CLK(clk), .RESET_N(rst_n),
        .IN_VALID(b_in_vld), .IN_READY(b_in_rdy), .IN_MODE(b_in_mode), .IN_DATA(b_in_dat),
        .OUT_VALID(b_out_vld), .OUT_READY(1'b1), .OUT_DATA(b_out_dat), .OUT_SAT(b_out_sat),
        .SAT_STICKY(b_sticky), .CLR_SAT(1'b0)
    );

    function automatic logic [W-1:0] sm(input int v);
        return (v < 0) ? {1'b1, 11'(-v)} : {1'b0, 11'(v)};
    endfunction

    function automatic logic [DW-1:0] ln(input int k, input logic [W-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        r[k*W +: W] = v;
        return r;
    endfunction

    task automatic chk_dat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    always begin : mon_a
        exp_t e;
        @(negedge clk);
        #2;
        if (out_vld && out_rdy) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_beat got=%h want=no_beat", out_dat);
            end else begin
                e = qa.pop_front();
                chk_dat("a_out_dat", out_dat, e.dat);
                chk_bit("a_out_sat", out_sat, e.sat);
            end
        end
    end

    always begin : mon_b
        exp_t e;
        @(negedge clk);
        #2;
        if (b_out_vld) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_beat got=%h want=no_beat", b_out_dat);
            end else begin
                e = qb.pop_front();
                chk_dat("b_out_dat", b_out_dat, e.dat);
                chk_bit("b_out_sat", b_out_sat, e.sat);
            end
        end
    end

    task automatic send_a(input logic [1:0] m, input logic [DW-1:0] d, input logic [DW-1:0] ed, input logic es);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        in_vld = 1'b1; in_mode = m; in_dat = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            #1;
            acc = in_rdy;
            @(posedge clk);
            if (acc) qa.push_back('{dat: ed, sat: es});
            else @(negedge clk);
        end
        #1;
        in_vld = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_a_timeout got=stalled want=accept");
        end
    endtask

    task automatic send_b(input logic [1:0] m, input logic [DW-1:0] d, input logic [DW-1:0] ed, input logic es);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        b_in_vld = 1'b1; b_in_mode = m; b_in_dat = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            #1;
            acc = b_in_rdy;
            @(posedge clk);
            if (acc) qb.push_back('{dat: ed, sat: es});
            else @(negedge clk);
        end
        #1;
        b_in_vld = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_b_timeout got=stalled want=accept");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        logic [DW-1:0] va, vb, vc, ea, ec;
        rst_n = 1'b1; in_vld = 1'b0; in_mode = 2'd0; in_dat = '0;
        out_rdy = 1'b1; clr_sat = 1'b0;
        b_in_vld = 1'b0; b_in_mode = 2'd0; b_in_dat = '0;
        #1 rst_n = 1'b0;
        #1;
        chk_bit("rst_out_vld", out_vld, 1'b0);
        chk_dat("rst_out_dat", out_dat, '0);
        chk_bit("rst_out_sat", out_sat, 1'b0);
        chk_bit("rst_sticky", sticky, 1'b0);
        chk_bit("rst_b_out_vld", b_out_vld, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("rdy_after_rst", in_rdy, 1'b1);

        // scale: +1000 -> +1414, -1500 -> -2121 clamps to -2047
        send_a(2'd1, ln(0, sm(1000)) | ln(4, sm(-1500)), ln(0, sm(1414)) | ln(4, sm(-2047)), 1'b1);
        @(negedge clk); #1;
        chk_bit("lat_not_yet", out_vld, 1'b0);
        @(negedge clk); #1;
        chk_bit("lat_out_vld", out_vld, 1'b1);
        chk_bit("sticky_before_xfer", sticky, 1'b0);
        @(negedge clk); #1;
        chk_bit("sticky_set", sticky, 1'b1);
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        #1;
        chk_bit("sticky_clr", sticky, 1'b0);

        // butterfly: mixed signs, both negative, -0 input, equal-and-opposite giving +0
        send_a(2'd0,
               ln(0, sm(-300)) | ln(1, sm(-100)) | ln(2, sm(500)) | ln(3, sm(-200)) |
               ln(4, 12'h800) | ln(5, sm(5)) | ln(6, sm(-50)) | ln(7, sm(50)),
               ln(0, sm(-400)) | ln(1, sm(-200)) | ln(2, sm(300)) | ln(3, sm(700)) |
               ln(4, sm(5)) | ln(5, sm(-5)) | ln(6, 12'h000) | ln(7, sm(-100)), 1'b0);
        repeat (3) @(negedge clk);

        // saturation and zero, with CLR_SAT held across the set event
        clr_sat = 1'b1;
        send_a(2'd0, ln(0, sm(100)) | ln(1, sm(100)) | ln(6, sm(1500)) | ln(7, sm(1000)),
               ln(0, sm(200)) | ln(6, sm(2047)) | ln(7, sm(500)), 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        chk_bit("clr_no_set", sticky, 1'b0);
        @(negedge clk); #1;
        chk_bit("set_beats_clr", sticky, 1'b1);
        clr_sat = 1'b0;
        repeat (2) @(negedge clk);

        // backpressure with mode changing every beat
        va = ln(0, sm(1)) | ln(1, sm(2));
        ea = ln(0, sm(3)) | ln(1, sm(-1));
        vb = ln(3, 12'h800) | ln(5, sm(-33)) | ln(7, 12'hABC);
        vc = ln(1, sm(2000)) | ln(2, sm(10)) | ln(3, sm(4));
        ec = ln(1, sm(2047)) | ln(2, sm(14)) | ln(3, sm(6));
        out_rdy = 1'b0;
        send_a(2'd0, va, ea, 1'b0);
        send_a(2'd2, vb, vb, 1'b0);
        @(negedge clk);
        in_vld = 1'b1; in_mode = 2'd1; in_dat = vc;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_bit("bp_in_rdy_low", in_rdy, 1'b0);
            chk_bit("bp_out_vld", out_vld, 1'b1);
            chk_dat("bp_hold_a", out_dat, ea);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        #1;
        chk_bit("bp_a_vld", out_vld, 1'b1);
        chk_bit("bp_c_rdy", in_rdy, 1'b1);
        @(posedge clk);
        qa.push_back('{dat: ec, sat: 1'b1});
        #1;
        in_vld = 1'b0;
        @(negedge clk); #1;
        chk_bit("bp_b_vld", out_vld, 1'b1);
        @(negedge clk); #1;
        chk_bit("bp_c_vld", out_vld, 1'b1);

        // STRIDE 4 stage: butterfly, bypass (modes 2 and 3), mismatched scale mask
        send_b(2'd0, ln(1, sm(10)) | ln(5, sm(3)) | ln(3, sm(-9)) | ln(7, sm(4)),
               ln(1, sm(13)) | ln(5, sm(7)) | ln(3, sm(-5)) | ln(7, sm(-13)), 1'b0);
        send_b(2'd2, 96'hFED_CBA_987_654_321_800_7FF_001, 96'hFED_CBA_987_654_321_800_7FF_001, 1'b0);
        send_b(2'd3, 96'h800_800_123_FFF_000_456_ABC_0F0, 96'h800_800_123_FFF_000_456_ABC_0F0, 1'b0);
        send_b(2'd1,
               ln(0, sm(1000)) | ln(4, sm(-7)) | ln(2, sm(20)) | ln(6, sm(-20)) | ln(1, sm(100)) | ln(5, sm(3)),
               ln(0, sm(1414)) | ln(4, sm(-7)) | ln(2, 12'h000) | ln(6, sm(40)) | ln(1, sm(141)) | ln(5, sm(3)),
               1'b0);
        drain();
        chk_int("qa_drained", qa.size(), 0);
        chk_int("qb_drained", qb.size(), 0);

        // reset with two beats in flight
        send_a(2'd0, ln(0, sm(7)), ln(0, sm(7)) | ln(1, sm(7)), 1'b0);
        send_a(2'd0, ln(2, sm(9)), ln(2, sm(9)) | ln(3, sm(9)), 1'b0);
        chk_bit("pre_rst_vld", out_vld, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("rst_mid_vld", out_vld, 1'b0);
        chk_dat("rst_mid_dat", out_dat, '0);
        qa.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("rdy_after_rst2", in_rdy, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk_bit("no_stale_beat", out_vld, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
